// File: rtl/multicycle_cpu_pkg.sv
// Shared definitions for the multi-cycle CPU core: opcodes, FSM states and
// instruction field positions derived from the register index width.
package multicycle_cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_MUL  = 4'h8,
        OP_LDI  = 4'h9,
        OP_MOV  = 4'hA,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    // Instruction layout is {opcode[3:0], dest, src1, src2}, MSB first.
    function automatic int op_lsb(input int aw);
        return 3 * aw;
    endfunction

    function automatic int dest_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int src1_lsb(input int aw);
        return aw;
    endfunction

endpackage

// File: rtl/multicycle_cpu_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port. r0 has no storage; it always reads 0 and ignores writes.
module cpu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [1:NREGS-1];

    // Storage for r1..r(NREGS-1), cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational reads with r0 forced to zero.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: accepts one instruction per valid/ready handshake and
// walks it through decode, execute and writeback, reporting result and flags.
// Optional multiplier (opcode 8) enabled by defining MULTICYCLE_CPU_MUL_EN.
//
// state     | meaning
// ST_IDLE   | waiting for an instruction (instr_ready high)
// ST_DECODE | operands read from the register file
// ST_EXEC   | ALU result and next flags registered
// ST_WB     | register write, result_valid pulse
// ST_HALT   | stopped by HALT until reset
module multicycle_cpu
    import multicycle_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    localparam int REG_AW  = $clog2(NREGS),
    localparam int INSTR_W = 4 + 3 * REG_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic               result_valid,
    output logic [DATA_W-1:0]  result,
    output logic               illegal,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               halted
);

    localparam int unsigned SH_LIM_I = DATA_W;
    localparam logic [DATA_W-1:0] SH_LIM = SH_LIM_I[DATA_W-1:0];

    state_t             state;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic               wb_en;

    logic [3:0]         opcode;
    logic [REG_AW-1:0]  dest;
    logic [REG_AW-1:0]  src1;
    logic [REG_AW-1:0]  src2;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;

    logic [DATA_W-1:0]  alu_res;
    logic               alu_c;
    logic               alu_wr;
    logic               alu_ill;
    logic               alu_halt;
    logic [DATA_W:0]    sum;

    assign opcode = instr_q[op_lsb(REG_AW) +: 4];
    assign dest   = instr_q[dest_lsb(REG_AW) +: REG_AW];
    assign src1   = instr_q[src1_lsb(REG_AW) +: REG_AW];
    assign src2   = instr_q[REG_AW-1:0];
    assign sum    = {1'b0, op_a} + {1'b0, op_b};

    cpu_regfile #(
        .DATA_W(DATA_W),
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .raddr1(src1),
        .raddr2(src2),
        .rdata1(rd1),
        .rdata2(rd2),
        .we    ((state == ST_WB) && wb_en),
        .waddr (dest),
        .wdata (result)
    );

`ifdef MULTICYCLE_CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = op_a * op_b;
`endif

    // ALU: result, carry and write/illegal/halt classification per opcode.
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_wr   = 1'b1;
        alu_ill  = 1'b0;
        alu_halt = 1'b0;
        case (opcode)
            OP_NOP:  alu_wr = 1'b0;
            OP_ADD:  begin alu_res = sum[DATA_W-1:0]; alu_c = sum[DATA_W]; end
            OP_SUB:  begin alu_res = op_a - op_b; alu_c = (op_a < op_b); end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = (op_b >= SH_LIM) ? '0 : (op_a << op_b);
            OP_SHR:  alu_res = (op_b >= SH_LIM) ? '0 : (op_a >> op_b);
            OP_LDI:  alu_res = DATA_W'({src1, src2});
            OP_MOV:  alu_res = op_a;
`ifdef MULTICYCLE_CPU_MUL_EN
            OP_MUL:  begin alu_res = prod[DATA_W-1:0]; alu_c = |prod[2*DATA_W-1:DATA_W]; end
`endif
            OP_HALT: begin alu_wr = 1'b0; alu_halt = 1'b1; end
            default: begin alu_wr = 1'b0; alu_ill = 1'b1; end
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            instr_q      <= '0;
            op_a         <= '0;
            op_b         <= '0;
            wb_en        <= 1'b0;
            instr_ready  <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            illegal      <= 1'b0;
            zero_flag    <= 1'b0;
            carry_flag   <= 1'b0;
            halted       <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            illegal      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    instr_ready <= 1'b1;
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instruction;
                        instr_ready <= 1'b0;
                        state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    op_a  <= rd1;
                    op_b  <= rd2;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (alu_halt) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        result       <= alu_res;
                        result_valid <= 1'b1;
                        illegal      <= alu_ill;
                        wb_en        <= alu_wr;
                        if (alu_wr) begin
                            zero_flag  <= (alu_res == '0);
                            carry_flag <= alu_c;
                        end
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu with a behavioural reference model.
module tb_multicycle_cpu;

    localparam int DATA_W  = 8;
    localparam int NREGS   = 8;
    localparam int AW      = 3;
    localparam int INSTR_W = 4 + 3 * AW;
    localparam int MOD     = 1 << DATA_W;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               instr_valid = 1'b0;
    logic [INSTR_W-1:0] instruction = '0;
    logic               instr_ready;
    logic               result_valid;
    logic [DATA_W-1:0]  result;
    logic               illegal;
    logic               zero_flag;
    logic               carry_flag;
    logic               halted;

    multicycle_cpu #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .result_valid(result_valid), .result(result),
        .illegal(illegal), .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int m_regs [NREGS];
    bit m_z, m_c;

    function automatic logic [INSTR_W-1:0] mk(input int op, input int d, input int s1, input int s2);
        logic [3:0] o = op[3:0];
        logic [AW-1:0] a = d[AW-1:0];
        logic [AW-1:0] b = s1[AW-1:0];
        logic [AW-1:0] c = s2[AW-1:0];
        return {o, a, b, c};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        m_z = 0;
        m_c = 0;
    endtask

    // Architectural effect of one instruction, from the opcode rules.
    task automatic model_exec(input logic [INSTR_W-1:0] ins, output logic [DATA_W-1:0] er, output bit eill);
        int op, d, s1, s2, a, b, r;
        bit wr, c;
        op = int'(ins[INSTR_W-1 -: 4]);
        d  = int'(ins[3*AW-1 -: AW]);
        s1 = int'(ins[2*AW-1 -: AW]);
        s2 = int'(ins[AW-1:0]);
        a = m_regs[s1];
        b = m_regs[s2];
        r = 0; wr = 1; c = 0; eill = 0;
        case (op)
            0:  wr = 0;
            1:  begin r = a + b; c = (r >= MOD); r = r % MOD; end
            2:  begin c = (a < b); r = (a - b + MOD) % MOD; end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = (b >= DATA_W) ? 0 : (a * (1 << b)) % MOD;
            7:  r = (b >= DATA_W) ? 0 : a / (1 << b);
`ifdef MULTICYCLE_CPU_MUL_EN
            8:  begin r = a * b; c = (r >= MOD); r = r % MOD; end
`endif
            9:  r = (s1 * NREGS + s2) % MOD;
            10: r = a;
            default: begin wr = 0; eill = 1; end
        endcase
        if (wr) begin
            m_z = (r == 0);
            m_c = c;
            if (d != 0) m_regs[d] = r;
        end
        er = r[DATA_W-1:0];
    endtask

    // Offers one instruction and captures what the core reports for it.
    task automatic run_instr(input logic [INSTR_W-1:0] ins, output int lat,
                             output logic [DATA_W-1:0] got_res, output logic got_ill,
                             output logic got_z, output logic got_c, output bit busy_ready,
                             output logic rv_after, output logic ready_after);
        int w = 0;
        while (!instr_ready && w < 20) begin @(negedge clk); w++; end
        instr_valid = 1'b1;
        instruction = ins;
        @(negedge clk);
        instr_valid = 1'b0;
        instruction = INSTR_W'($urandom);
        lat = -1; got_res = 'x; got_ill = 1'bx; busy_ready = 0;
        for (int c = 1; c <= 8; c++) begin
            if (instr_ready) busy_ready = 1;
            if (result_valid) begin
                lat = c; got_res = result; got_ill = illegal;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        got_z = zero_flag;
        got_c = carry_flag;
        rv_after = result_valid;
        ready_after = instr_ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({instr_ready, result_valid, illegal, zero_flag, carry_flag, halted} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {instr_ready, result_valid, illegal, zero_flag, carry_flag, halted});
        end
        tests_run++;
        if (result !== '0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h required 00", result);
        end
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %b required 1", instr_ready);
        end
    endtask

    task automatic test_ldi_latency();
        int lat; logic [DATA_W-1:0] r, er; logic il, z, c, rva, rda; bit busy, eil;
        model_exec(mk(9, 1, 0, 5), er, eil);
        run_instr(mk(9, 1, 0, 5), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (lat != 3) begin tests_failed++; $display("FAIL ldi_latency: got %0d required 3", lat); end
        tests_run++;
        if (r !== 8'd5 || il !== 1'b0) begin
            tests_failed++; $display("FAIL ldi_result: got %h ill %b required 05 ill 0", r, il);
        end
        tests_run++;
        if (z !== 1'b0 || c !== 1'b0) begin
            tests_failed++; $display("FAIL ldi_flags: got z%b c%b required z0 c0", z, c);
        end
        tests_run++;
        if (busy || rva !== 1'b0 || rda !== 1'b1) begin
            tests_failed++;
            $display("FAIL ldi_handshake: busy_ready %b rv_after %b ready_after %b required 0 0 1", busy, rva, rda);
        end
    endtask

    task automatic test_arith();
        int lat; logic [DATA_W-1:0] r, er; logic il, z, c, rva, rda; bit busy, eil;
        logic [INSTR_W-1:0] seq [5];
        seq = '{mk(9, 1, 7, 7), mk(9, 2, 0, 2), mk(6, 1, 1, 2), mk(9, 5, 0, 3), mk(4, 1, 1, 5)};
        foreach (seq[i]) begin
            model_exec(seq[i], er, eil);
            run_instr(seq[i], lat, r, il, z, c, busy, rva, rda);
        end
        tests_run++;
        if (r !== 8'hFF) begin tests_failed++; $display("FAIL build_ff: got %h required ff", r); end
        model_exec(mk(1, 3, 1, 1), er, eil);
        run_instr(mk(1, 3, 1, 1), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (r !== 8'hFE || c !== 1'b1 || z !== 1'b0 || lat != 3) begin
            tests_failed++; $display("FAIL add_carry: got %h c%b z%b lat %0d required fe c1 z0 lat 3", r, c, z, lat);
        end
        model_exec(mk(2, 4, 0, 1), er, eil);
        run_instr(mk(2, 4, 0, 1), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (r !== 8'h01 || c !== 1'b1 || z !== 1'b0) begin
            tests_failed++; $display("FAIL sub_borrow: got %h c%b z%b required 01 c1 z0", r, c, z);
        end
    endtask

    task automatic test_r0();
        int lat; logic [DATA_W-1:0] r, er; logic il, z, c, rva, rda; bit busy, eil;
        model_exec(mk(10, 0, 1, 0), er, eil);
        run_instr(mk(10, 0, 1, 0), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (r !== 8'hFF) begin tests_failed++; $display("FAIL mov_r0_result: got %h required ff", r); end
        model_exec(mk(1, 2, 0, 0), er, eil);
        run_instr(mk(1, 2, 0, 0), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (r !== 8'h00 || z !== 1'b1 || c !== 1'b0) begin
            tests_failed++; $display("FAIL r0_reads_zero: got %h z%b c%b required 00 z1 c0", r, z, c);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [DATA_W-1:0] r, er; logic il, z, c, rva, rda; bit busy, eil;
        model_exec(mk(2, 6, 0, 1), er, eil);
        run_instr(mk(2, 6, 0, 1), lat, r, il, z, c, busy, rva, rda);
        model_exec(mk(4'hB, 1, 1, 1), er, eil);
        run_instr(mk(4'hB, 1, 1, 1), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (lat != 3 || il !== 1'b1 || r !== 8'h00) begin
            tests_failed++; $display("FAIL illegal_b: got lat %0d ill %b res %h required lat 3 ill 1 res 00", lat, il, r);
        end
        tests_run++;
        if (z !== 1'b0 || c !== 1'b1) begin
            tests_failed++; $display("FAIL illegal_flags_held: got z%b c%b required z0 c1", z, c);
        end
        model_exec(mk(10, 7, 1, 0), er, eil);
        run_instr(mk(10, 7, 1, 0), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (r !== 8'hFF) begin tests_failed++; $display("FAIL illegal_no_write: got %h required ff", r); end
        model_exec(mk(9, 6, 0, 3), er, eil);
        run_instr(mk(9, 6, 0, 3), lat, r, il, z, c, busy, rva, rda);
        model_exec(mk(9, 7, 0, 5), er, eil);
        run_instr(mk(9, 7, 0, 5), lat, r, il, z, c, busy, rva, rda);
        model_exec(mk(8, 2, 6, 7), er, eil);
        run_instr(mk(8, 2, 6, 7), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
`ifdef MULTICYCLE_CPU_MUL_EN
        if (r !== 8'd15 || il !== 1'b0 || c !== 1'b0) begin
            tests_failed++; $display("FAIL mul_3x5: got %h ill %b c%b required 0f ill 0 c0", r, il, c);
        end
`else
        if (r !== 8'd0 || il !== 1'b1) begin
            tests_failed++; $display("FAIL op8_illegal: got %h ill %b required 00 ill 1", r, il);
        end
`endif
        model_exec(mk(10, 5, 2, 0), er, eil);
        run_instr(mk(10, 5, 2, 0), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (r !== er) begin tests_failed++; $display("FAIL op8_dest_value: got %h required %h", r, er); end
    endtask

    task automatic test_random();
        int lat, op, bad; logic [DATA_W-1:0] r, er; logic il, z, c, rva, rda; bit busy, eil;
        logic [INSTR_W-1:0] ins;
        bad = 0;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 14);
            if ($urandom_range(0, 3) == 0) op = 9;
            ins = mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            model_exec(ins, er, eil);
            run_instr(ins, lat, r, il, z, c, busy, rva, rda);
            tests_run++;
            if (lat != 3 || r !== er || il !== eil || z !== m_z || c !== m_c || busy || rva !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_%0d op %h: got lat %0d res %h ill %b z%b c%b busy %b required lat 3 res %h ill %b z%b c%b busy 0",
                         n, op, lat, r, il, z, c, busy, er, eil, m_z, m_c);
            end
        end
    endtask

    task automatic test_halt();
        int lat; logic [DATA_W-1:0] r, er; logic il, z, c, rva, rda; bit busy, eil, bad;
        int w = 0;
        while (!instr_ready && w < 20) begin @(negedge clk); w++; end
        instr_valid = 1'b1;
        instruction = mk(15, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (halted !== 1'b0) begin tests_failed++; $display("FAIL halt_early: got %b required 0", halted); end
        @(negedge clk);
        tests_run++;
        if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_set: got %b required 1", halted); end
        bad = 0;
        repeat (20) begin
            instruction = INSTR_W'($urandom);
            @(negedge clk);
            if (halted !== 1'b1 || instr_ready !== 1'b0 || result_valid !== 1'b0) bad = 1;
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("FAIL halt_terminal: got activity while halted required none"); end
        instr_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        w = 0;
        while (!instr_ready && w < 5) begin @(negedge clk); w++; end
        tests_run++;
        if (instr_ready !== 1'b1 || halted !== 1'b0) begin
            tests_failed++; $display("FAIL halt_reset_ready: got ready %b halted %b required 1 0", instr_ready, halted);
        end
        model_exec(mk(4, 5, 1, 3), er, eil);
        run_instr(mk(4, 5, 1, 3), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (r !== 8'h00 || lat != 3) begin
            tests_failed++; $display("FAIL regs_cleared: got %h lat %0d required 00 lat 3", r, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [DATA_W-1:0] r, er; logic il, z, c, rva, rda; bit busy, eil, seen;
        int w = 0;
        model_exec(mk(9, 1, 0, 7), er, eil);
        run_instr(mk(9, 1, 0, 7), lat, r, il, z, c, busy, rva, rda);
        while (!instr_ready && w < 20) begin @(negedge clk); w++; end
        instr_valid = 1'b1;
        instruction = mk(1, 2, 1, 1);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (result_valid !== 1'b0) seen = 1;
        end
        reset = 1'b1;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            if (result_valid !== 1'b0) seen = 1;
        end
        tests_run++;
        if (seen) begin tests_failed++; $display("FAIL abort_no_result: got result_valid 1 required 0"); end
        model_exec(mk(1, 3, 2, 1), er, eil);
        run_instr(mk(1, 3, 2, 1), lat, r, il, z, c, busy, rva, rda);
        tests_run++;
        if (r !== 8'h00 || z !== 1'b1) begin
            tests_failed++; $display("FAIL abort_no_write: got %h z%b required 00 z1", r, z);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_latency();
        test_arith();
        test_r0();
        test_illegal();
        test_random();
        test_reset_mid();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
Parametrised multi-cycle CPU core; next generation of the single-cycle CPU top. Accepts one instruction per valid/ready handshake, sequences it through decode, execute and writeback with an explicit FSM, and reports result plus flags. Sits between the instruction source and downstream result consumer; register file, ALU and control live inside it.

Parameters:
DATA_W, 8, datapath and register width (>=4)
NREGS, 8, number of architectural registers (power of 2, >=4)
REG_AW, $clog2(NREGS), register index width (derived, not overridable)
INSTR_W, 4+3*REG_AW, instruction width (derived)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  core can accept an instruction
instruction  in  INSTR_W  {opcode[3:0], dest, src1, src2}, MSB first
result_valid  out  1  one-cycle pulse, instruction retired
result  out  DATA_W  value produced by retired instruction
illegal  out  1  pulses with result_valid when retired opcode is undefined
zero_flag  out  1  registered zero flag
carry_flag  out  1  registered carry/borrow flag
halted  out  1  core stopped by HALT

Behaviour:
- Reset (reset=0, async assert, sync deassert): state IDLE, all registers 0, result 0, result_valid/illegal/flags/halted 0, instr_ready 0 while asserted.
- FSM: IDLE -> (instr_valid & instr_ready) latch instruction -> DECODE (read src1/src2 into operand regs) -> EXEC (ALU result + next flags registered) -> WB (regfile write if applicable; result_valid=1) -> IDLE. HALT in EXEC -> HALT state, terminal until reset.
- instr_ready=1 only in IDLE. Accept in cycle N -> result_valid in cycle N+3; next accept earliest N+4. instruction ignored when not accepted.
- r0 reads as 0; writes to r0 discarded (result still reported).
- Opcodes: 0 NOP (no write, result 0, flags unchanged); 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 SHL by rs2 value; 7 SHR logical by rs2 value; 9 LDI dest <= zero-extended {src1,src2} field bits, truncated to DATA_W; A MOV dest <= rs1; F HALT; all others illegal.
- Arithmetic mod 2^DATA_W. ADD carry = carry out; SUB carry = borrow (rs1<rs2 unsigned). Logic/shift/LDI/MOV clear carry. Shift amount >= DATA_W yields 0.
- zero_flag = (result==0) for every writing opcode; unchanged for NOP/illegal/HALT.
- Illegal: no write, flags unchanged, result 0, illegal=1 with result_valid.
- HALT: no write, no result_valid; halted=1 from cycle after EXEC; instr_ready stays 0.
- Reset mid-instruction: aborted, no writeback, no result_valid.
- Flags update in WB cycle, visible from following cycle with result.

Optional Feature:
MULTICYCLE_CPU_MUL_EN: defined -> opcode 8 MUL, dest <= low DATA_W bits of rs1*rs2, carry = (high half != 0), same 3-cycle latency. Undefined -> opcode 8 illegal, no multiplier synthesised.

Decomposition:
- Package multicycle_cpu_pkg: opcode constants/enum, FSM state enum, field-position functions from REG_AW.
- One sub-module: cpu_regfile (NREGS x DATA_W, two async read ports, one sync write port, r0 hardwired 0, async active-low reset clears).
- ALU and control remain inline in multicycle_cpu.

Test Plan:
- Reset then LDI r1,5 accepted cycle N -> result_valid at N+3, result=5, zero=0, carry=0; instr_ready low N+1..N+3.
- DATA_W=8: LDI r1,0xFF-equivalent via LDI+SHL, then ADD r3,r1,r1 (r1=0xFF) -> result 0xFE, carry=1; SUB r4,r0,r1 -> result 0x01, carry=1.
- MOV r0,r1 -> result reports r1 value, subsequent ADD r2,r0,r0 -> result 0, zero=1.
- Opcode 0xB -> illegal=1 with result_valid, no register changed, flags held; opcode 8 illegal unless MULTICYCLE_CPU_MUL_EN (then 3*5 -> 15).
- HALT -> halted=1, instr_ready=0 indefinitely with instr_valid held high; reset -> ready restored, registers 0.
- Assert reset during EXEC of ADD r2 -> no result_valid, r2 reads 0 after reset.
